// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor. One full-subtractor cell and a
//   registered borrow handle one bit per clock, LSB first. The result is
//   D = (A - B - Bin) mod 2^WIDTH, with Bout = 1 when A < B + Bin (unsigned).
//
//   state | meaning
//   IDLE  | waiting for start; operands are captured on an accepted start
//   RUN   | one cell evaluation and shift per cycle, WIDTH cycles in total
//   DONE  | D/Bout valid with a one-cycle done pulse; always returns to IDLE
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   start : request, sampled only in IDLE
//   A, B  : minuend / subtrahend, captured on an accepted start
//   Bin   : borrow-in, captured on an accepted start
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse when D/Bout are updated
//   D     : registered difference, held until the next DONE
//   Bout  : registered borrow-out, held until the next DONE
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, sd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic a0, b0, d_bit, br_next;

  // Full-subtractor cell on the current operand LSBs.
  always_comb begin
    a0      = sa[0];
    b0      = sb[0];
    d_bit   = a0 ^ b0 ^ br;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Both are decoded from the state register only, so no input reaches them
  // combinationally.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= A;
            sb  <= B;
            br  <= Bin;
            cnt <= '0;
            sd  <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          // Difference bits enter at the MSB so that after WIDTH shifts the
          // first (LSB) result bit has arrived at bit 0.
          sd  <= {d_bit, sd[WIDTH-1:1]};
          br  <= br_next;
          cnt <= cnt + CW'(1);
          // On the final bit the completed word goes straight to the output
          // registers, so they change only on the edge entering DONE.
          if (cnt == LAST) begin
            D    <= {d_bit, sd[WIDTH-1:1]};
            Bout <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         busy, done;
  logic [W-1:0] D;
  logic         Bout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] last_d;
  logic         last_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an operation at the next edge (edge 0) and follow it to the end of
  // DONE (edge W+1), checking the cycle-exact timing along the way.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] exp_d, input logic exp_bout, input string tag);
    A = a; B = b; Bin = bin; start = 1'b1;
    step();
    start = 1'b0;
    // Operand inputs are scrambled during RUN; they must not matter.
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    check({tag, ".busy_e0"}, 32'(busy), 32'd1);
    check({tag, ".done_e0"}, 32'(done), 32'd0);
    for (int i = 1; i < W; i++) begin
      step();
      check({tag, ".run_busy"}, 32'(busy), 32'd1);
      check({tag, ".run_done"}, 32'(done), 32'd0);
      check({tag, ".run_hold"}, 32'({Bout, D}), 32'({last_bout, last_d}));
    end
    step();
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_dn"}, 32'(busy), 32'd1);
    check({tag, ".D"}, 32'(D), 32'(exp_d));
    check({tag, ".Bout"}, 32'(Bout), 32'(exp_bout));
    last_d = exp_d;
    last_bout = exp_bout;
    step();
    check({tag, ".done_off"}, 32'(done), 32'd0);
    check({tag, ".busy_off"}, 32'(busy), 32'd0);
  endtask

  logic [W:0] ref_val;

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    int           seen_done;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    last_d = '0; last_bout = 1'b0;

    // Reset then idle.
    repeat (3) step();
    check("rst.D", 32'(D), 32'h0);
    check("rst.Bout", 32'(Bout), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    rst = 1'b0;
    seen_done = 0;
    repeat (10) begin
      step();
      if (done || busy) seen_done++;
    end
    check("idle.no_activity", 32'(seen_done), 32'd0);
    check("idle.D", 32'(D), 32'h0);

    // Directed cases.
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "basic");
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "wrap");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "zero_bin");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "eq_bin");
    run_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "max");

    // Busy lockout: extra starts at edge 4 and in the DONE cycle.
    A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
    step();                                   // edge 0
    start = 1'b0;
    repeat (3) step();                        // edges 1..3
    A = 8'h00; B = 8'hFF; start = 1'b1;
    step();                                   // edge 4
    start = 1'b0;
    check("lock.busy_e4", 32'(busy), 32'd1);
    repeat (3) step();                        // edges 5..7
    check("lock.no_early_done", 32'(done), 32'd0);
    step();                                   // edge 8
    check("lock.done", 32'(done), 32'd1);
    check("lock.D", 32'(D), 32'h0F);
    check("lock.Bout", 32'(Bout), 32'h0);
    start = 1'b1;
    step();                                   // edge 9, start in DONE ignored
    start = 1'b0;
    check("lock.busy_off", 32'(busy), 32'd0);
    seen_done = 0;
    repeat (12) begin
      step();
      if (done || busy) seen_done++;
    end
    check("lock.ignored", 32'(seen_done), 32'd0);
    check("lock.D_hold", 32'(D), 32'h0F);
    last_d = 8'h0F; last_bout = 1'b0;

    // Reset mid-operation.
    A = 8'h80; B = 8'h01; Bin = 1'b0; start = 1'b1;
    step();                                   // edge 0
    start = 1'b0;
    repeat (4) step();                        // edges 1..4
    rst = 1'b1;
    step();                                   // edge 5
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.D", 32'(D), 32'h0);
    check("abort.Bout", 32'(Bout), 32'h0);
    last_d = '0; last_bout = 1'b0;
    seen_done = 0;
    repeat (W + 2) begin
      step();
      if (done) seen_done++;
    end
    check("abort.no_done", 32'(seen_done), 32'd0);

    // Back-to-back: second start lands at edge W+2 of the first.
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "b2b1");
    run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, "b2b2");

    // Random operations with random idle gaps.
    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step();
        check("rand.gap_done", 32'(done), 32'd0);
        check("rand.gap_hold", 32'({Bout, D}), 32'({last_bout, last_d}));
      end
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      ref_val = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      run_op(ra, rb, rbin, ref_val[W-1:0], ref_val[W], "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor built around a single full-subtractor cell and a registered borrow. It is the inverse-operation companion of the one-bit full adder block. It accepts two operands and a borrow-in on a start strobe, processes one bit per clock LSB-first, then presents the difference and borrow-out with a one-cycle done pulse. It serves area-constrained datapaths where latency is traded for a single arithmetic cell.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  minuend; captured on accepted start.
- B  in  WIDTH  subtrahend; captured on accepted start.
- Bin  in  1  borrow-in; captured on accepted start.
- busy  out  1  high while in RUN or DONE.
- done  out  1  one-cycle pulse marking D/Bout valid.
- D  out  WIDTH  difference, registered.
- Bout  out  1  borrow-out, registered.

## Operation
- Function: D = (A − B − Bin) mod 2^WIDTH. Bout = 1 iff A < B + Bin, unsigned.
- Per-bit cell, with a0/b0 the current LSBs of the operand shift registers and br the borrow register:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
- Internal state:
  - operand shift registers sa, sb, each WIDTH bits, shifted right once per RUN cycle;
  - result shift register sd, filled MSB-first with d each RUN cycle;
  - br, 1 bit;
  - bit counter cnt, clog2(WIDTH+1) bits.
- FSM:
  - IDLE: busy=0. If start=1, load sa=A, sb=B, br=Bin, cnt=0, sd=0, and go to RUN.
  - RUN: busy=1. Each cycle apply the cell, shift sa/sb/sd, cnt++. When cnt reaches WIDTH−1 this cycle, go to DONE.
  - DONE: busy=1, done=1 for exactly this cycle. D and Bout were loaded on the entering edge. Always returns to IDLE.
- Output holding:
  - D and Bout change only on the edge entering DONE.
  - They hold that value through IDLE and the next RUN until the next DONE.
- start handling:
  - start while busy=1 is ignored. There is no queueing, and A/B/Bin changes during RUN have no effect.
  - start in the DONE cycle is ignored; a new operation needs start high in an IDLE cycle.
- Reset:
  - rst=1 at any edge forces IDLE with D=0, Bout=0, busy=0, done=0, br=0, cnt=0, and sa/sb/sd cleared.
  - rst overrides start on the same edge.
  - Reset mid-RUN aborts the operation: no done, and D/Bout read 0.

## Timing
- Reset values: D=0, Bout=0, busy=0, done=0, state IDLE.
- Edge numbering: start sampled high at edge 0 in IDLE.
  - busy rises after edge 0.
  - RUN occupies cycles after edges 0..WIDTH−1, exactly WIDTH bit cycles.
  - D/Bout update and done=1 take effect after edge WIDTH.
  - done and busy fall after edge WIDTH+1.
- Latency from start sample to done: WIDTH+1 edges. Throughput: one operation per WIDTH+2 cycles (next start accepted at edge WIDTH+2).
- All outputs are registered; there is no combinational path from inputs to outputs.
- Boundary conditions:
  - Wrap-around (A < B+Bin) yields the modular result with Bout=1.
  - A=B with Bin=1 yields all-ones with Bout=1.
  - The maximum operands 2^WIDTH−1 are handled without overflow of cnt.

## Test plan
All cases use WIDTH=8.
- Reset then idle: rst high 3 cycles, then start=0 for 10 cycles -> D=0x00, Bout=0, busy=0, done never asserted.
- Basic: A=0x05, B=0x03, Bin=0, start at edge 0 -> busy after edge 0; done=1 for one cycle after edge 8; D=0x02, Bout=0; busy low after edge 9.
- Wrap and borrow cases:
  - A=0x03, B=0x05, Bin=0 -> D=0xFE, Bout=1.
  - A=0x00, B=0x00, Bin=1 -> D=0xFF, Bout=1.
  - A=0xFF, B=0xFF, Bin=1 -> D=0xFF, Bout=1.
  - A=0xFF, B=0x00, Bin=0 -> D=0xFF, Bout=0.
- Busy lockout:
  - Start A=0x10, B=0x01, Bin=0.
  - Pulse start with A=0x00, B=0xFF at edge 4, then again in the DONE cycle.
  - Required: a single done with D=0x0F, Bout=0; second start ignored; D holds 0x0F afterwards.
- Reset mid-operation and back-to-back:
  - Start A=0x80, B=0x01; assert rst at edge 5 -> no done, D=0x00, busy=0 after edge 5.
  - Then start A=0x80, B=0x01 in IDLE -> D=0x7F, Bout=0, done exactly WIDTH+1 edges later.
  - Then immediately start A=0x01, B=0x02 at edge WIDTH+2 -> D=0xFF, Bout=1.
- Randomized scoreboard: 1000 random A/B/Bin with random start spacing -> every done matches the (A−B−Bin) reference model; D stays stable between dones.
